// File: rtl/btn_debounce_if.sv
// rtl/btn_debounce_if.sv - button conditioner bus: raw pins in, clean level and strobes out
// master drives the raw pins and observes the conditioned outputs; slave is the conditioner.
interface btn_debounce_if #(
  parameter int N_BTN = 3
);
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;
  logic [N_BTN-1:0] btn_long;

  modport master (
    output btn_raw,
    input  btn_level,
    input  btn_press,
    input  btn_release,
    input  btn_long
  );

  modport slave (
    input  btn_raw,
    output btn_level,
    output btn_press,
    output btn_release,
    output btn_long
  );
endinterface

// File: rtl/btn_debounce_ch.sv
// rtl/btn_debounce_ch.sv - single-channel synchroniser, debounce and long-press detector
// Every output is a flop; btn_raw only ever reaches the first synchroniser stage.
module btn_debounce_ch #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int LONG_CYCLES     = 50000000,
  parameter bit ACTIVE_LOW      = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_long
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] H_LAST = HW'(LONG_CYCLES - 1);

  logic          w_raw_pol;
  logic          r_s1;
  logic          r_s2;
  logic          r_level;
  logic          r_press;
  logic          r_release;
  logic          r_long;
  logic          r_long_done;
  logic [DW-1:0] r_dcnt;
  logic [HW-1:0] r_hcnt;

  assign w_raw_pol = ACTIVE_LOW ? ~btn_raw : btn_raw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= w_raw_pol;
      r_s2 <= r_s1;
    end
  end

  // Any return to the current level before acceptance restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dcnt    <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_press   <= 1'b0;
      r_release <= 1'b0;
      if (r_s2 == r_level) begin
        r_dcnt <= '0;
      end else if (r_dcnt == D_LAST) begin
        r_dcnt    <= '0;
        r_level   <= r_s2;
        r_press   <= r_s2;
        r_release <= ~r_s2;
      end else begin
        r_dcnt <= r_dcnt + 1'b1;
      end
    end
  end

  // hcnt is 0 in the press-strobe cycle, so btn_long lands LONG_CYCLES later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hcnt      <= '0;
      r_long      <= 1'b0;
      r_long_done <= 1'b0;
    end else begin
      r_long <= 1'b0;
      if (!r_level) begin
        r_hcnt <= '0;
      end else if (!r_long_done) begin
        if (r_hcnt == H_LAST) begin
          r_long      <= 1'b1;
          r_long_done <= 1'b1;
        end else begin
          r_hcnt <= r_hcnt + 1'b1;
        end
      end
      if (r_release) begin
        r_long_done <= 1'b0;
      end
    end
  end

  assign btn_level   = r_level;
  assign btn_press   = r_press;
  assign btn_release = r_release;
  assign btn_long    = r_long;
endmodule

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - N-channel button conditioner built from independent channel slices
// Channels share only clk and rst_n.
module btn_debounce #(
  parameter int N_BTN           = 3,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int LONG_CYCLES     = 50000000,
  parameter bit ACTIVE_LOW      = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  btn_debounce_if.slave      bus
);
  logic [N_BTN-1:0] w_level;
  logic [N_BTN-1:0] w_press;
  logic [N_BTN-1:0] w_release;
  logic [N_BTN-1:0] w_long;

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LONG_CYCLES     (LONG_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .btn_raw     (bus.btn_raw[g]),
      .btn_level   (w_level[g]),
      .btn_press   (w_press[g]),
      .btn_release (w_release[g]),
      .btn_long    (w_long[g])
    );
  end

  assign bus.btn_level   = w_level;
  assign bus.btn_press   = w_press;
  assign bus.btn_release = w_release;
  assign bus.btn_long    = w_long;
endmodule

// File: tb/tb_btn_debounce.sv
// tb/tb_btn_debounce.sv - directed self-checking bench for btn_debounce
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_btn_debounce;
  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  btn_debounce_if #(.N_BTN(3)) bif ();

  btn_debounce #(
    .N_BTN           (3),
    .DEBOUNCE_CYCLES (4),
    .LONG_CYCLES     (16),
    .ACTIVE_LOW      (1'b0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // expected {level, press, release, long}
  task automatic chk(input string tag, input logic [2:0] lvl, input logic [2:0] prs,
                     input logic [2:0] rel, input logic [2:0] lng);
    logic [11:0] obs;
    logic [11:0] exp;
    obs = {bif.btn_level, bif.btn_press, bif.btn_release, bif.btn_long};
    exp = {lvl, prs, rel, lng};
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: lvl/prs/rel/long got %b_%b_%b_%b expected %b_%b_%b_%b", tag,
             obs[11:9], obs[8:6], obs[5:3], obs[2:0], lvl, prs, rel, lng);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b1;
    bif.btn_raw = 3'b111;
    #2 rst_n = 1'b0;

    // 1: reset with all buttons held
    step(1);
    chk("rst_hold_a", 3'b000, 3'b000, 3'b000, 3'b000);
    step(2);
    chk("rst_hold_b", 3'b000, 3'b000, 3'b000, 3'b000);
    rst_n = 1'b1;
    step(5);
    chk("rst_e5", 3'b000, 3'b000, 3'b000, 3'b000);
    step(1);
    chk("rst_e6_press", 3'b111, 3'b111, 3'b000, 3'b000);
    step(1);
    chk("rst_e7", 3'b111, 3'b000, 3'b000, 3'b000);
    bif.btn_raw = 3'b000;
    step(6);
    chk("rst_release", 3'b000, 3'b000, 3'b111, 3'b000);
    step(1);
    chk("rst_idle", 3'b000, 3'b000, 3'b000, 3'b000);

    // 2: clean press on channel 0
    bif.btn_raw = 3'b001;
    step(5);
    chk("clean_e5", 3'b000, 3'b000, 3'b000, 3'b000);
    step(1);
    chk("clean_e6_press", 3'b001, 3'b001, 3'b000, 3'b000);
    step(1);
    chk("clean_e7", 3'b001, 3'b000, 3'b000, 3'b000);
    bif.btn_raw = 3'b000;
    step(5);
    chk("clean_rel_e5", 3'b001, 3'b000, 3'b000, 3'b000);
    step(1);
    chk("clean_rel_e6", 3'b000, 3'b000, 3'b001, 3'b000);
    step(1);

    // 3: bounce on channel 1, then hold
    for (int i = 0; i < 4; i++) begin
      bif.btn_raw = (i % 2 == 0) ? 3'b010 : 3'b000;
      step(1);
      chk("bounce_a", 3'b000, 3'b000, 3'b000, 3'b000);
      step(1);
      chk("bounce_b", 3'b000, 3'b000, 3'b000, 3'b000);
    end
    bif.btn_raw = 3'b010;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("bounce_settle", 3'b000, 3'b000, 3'b000, 3'b000);
    end
    step(1);
    chk("bounce_press", 3'b010, 3'b010, 3'b000, 3'b000);
    bif.btn_raw = 3'b000;
    step(6);
    chk("bounce_release", 3'b000, 3'b000, 3'b010, 3'b000);
    step(1);

    // 4: long press on channel 2
    bif.btn_raw = 3'b100;
    step(6);
    chk("long_press", 3'b100, 3'b100, 3'b000, 3'b000);
    for (int i = 1; i < 16; i++) begin
      step(1);
      chk("long_wait", 3'b100, 3'b000, 3'b000, 3'b000);
    end
    step(1);
    chk("long_fire", 3'b100, 3'b000, 3'b000, 3'b100);
    for (int i = 0; i < 18; i++) begin
      step(1);
      chk("long_norepeat", 3'b100, 3'b000, 3'b000, 3'b000);
    end
    bif.btn_raw = 3'b000;
    step(5);
    chk("long_rel_e5", 3'b100, 3'b000, 3'b000, 3'b000);
    step(1);
    chk("long_release", 3'b000, 3'b000, 3'b100, 3'b000);
    for (int i = 0; i < 20; i++) begin
      step(1);
      chk("long_after", 3'b000, 3'b000, 3'b000, 3'b000);
    end

    // 5: short press on channel 0, no long strobe
    bif.btn_raw = 3'b001;
    step(6);
    chk("short_press", 3'b001, 3'b001, 3'b000, 3'b000);
    for (int i = 0; i < 6; i++) begin
      step(1);
      chk("short_hold", 3'b001, 3'b000, 3'b000, 3'b000);
    end
    bif.btn_raw = 3'b000;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("short_fall", 3'b001, 3'b000, 3'b000, 3'b000);
    end
    step(1);
    chk("short_release", 3'b000, 3'b000, 3'b001, 3'b000);
    for (int i = 0; i < 20; i++) begin
      step(1);
      chk("short_nolong", 3'b000, 3'b000, 3'b000, 3'b000);
    end

    // 6: reset mid-debounce on channel 1 while channel 0 is already accepted
    bif.btn_raw = 3'b001;
    step(6);
    chk("mid_pre_press", 3'b001, 3'b001, 3'b000, 3'b000);
    step(1);
    bif.btn_raw = 3'b011;
    step(2);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_async_clear", 3'b000, 3'b000, 3'b000, 3'b000);
    step(2);
    chk("mid_in_reset", 3'b000, 3'b000, 3'b000, 3'b000);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("mid_settle", 3'b000, 3'b000, 3'b000, 3'b000);
    end
    step(1);
    chk("mid_press", 3'b011, 3'b011, 3'b000, 3'b000);
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("mid_single", 3'b011, 3'b000, 3'b000, 3'b000);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/btn_debounce.md
Name: btn_debounce

Overview:
Per-channel button conditioner that sits directly upstream of the board top-level logic. It takes raw, asynchronous, bouncing push-button inputs and synchronises and debounces them. It produces a clean level, single-cycle press/release strobes, and a single-cycle long-press strobe for the downstream LED/control logic. All channels are independent and share one clock domain.

Parameters:
N_BTN, 3, number of button channels
DEBOUNCE_CYCLES, 500000, consecutive stable synchronised cycles required to accept a new level (10 ms at 50 MHz); legal range >=1
LONG_CYCLES, 50000000, cycles the debounced level must stay high after a press to fire btn_long (1 s at 50 MHz); must be > DEBOUNCE_CYCLES
ACTIVE_LOW, 0, 1 = raw input is low when pressed (inverted before the synchroniser)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
btn_raw  input  N_BTN  raw button pins, asynchronous to clk
btn_level  output  N_BTN  debounced level, 1 = pressed
btn_press  output  N_BTN  1-cycle strobe on accepted 0->1 of btn_level
btn_release  output  N_BTN  1-cycle strobe on accepted 1->0 of btn_level
btn_long  output  N_BTN  1-cycle strobe when held LONG_CYCLES after press

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low. All state clears immediately on rst_n=0; deassertion is sampled on clk.
- Reset values: btn_level=0, btn_press=0, btn_release=0, btn_long=0, synchroniser flops=0 (after polarity), all counters=0, long_done=0.
- Polarity: if ACTIVE_LOW=1, invert btn_raw before the first flop.
- Synchroniser: 2 flops per channel (s1, s2). s2 is the only signal used downstream.
- Debounce counter dcnt, width $clog2(DEBOUNCE_CYCLES+1):
  - If s2 == btn_level, dcnt <= 0.
  - Else if dcnt == DEBOUNCE_CYCLES-1, btn_level <= s2 and dcnt <= 0.
  - Else dcnt <= dcnt+1.
  - Any bounce back to the current level before acceptance restarts the count from 0.
- Latency: with raw held constant, btn_level changes on the (DEBOUNCE_CYCLES+2)-th rising edge after the first edge that samples the new raw value. 2 of those cycles are the synchroniser.
- Strobes: btn_press/btn_release are registered and high for exactly the one cycle in which btn_level has just changed (same cycle btn_level shows the new value). They are never both high on one channel.
- Long press: hold counter hcnt, width $clog2(LONG_CYCLES+1).
  - Clears when btn_level=0.
  - Increments while btn_level=1 and long_done=0.
  - When hcnt reaches LONG_CYCLES-1, btn_long pulses for 1 cycle and long_done<=1. hcnt then holds (no wrap, no repeat).
  - long_done clears on the release strobe. One btn_long per press maximum.
  - Release before LONG_CYCLES means no btn_long.
- Counting origin: hcnt counts cycles from the press strobe cycle (cycle 0). btn_long is asserted exactly LONG_CYCLES cycles after btn_press.
- Simultaneous events: channels are fully independent; simultaneous presses on several channels give simultaneous strobes.
- Reset mid-operation: counters and levels drop to 0 asynchronously and no strobes are emitted during reset.
  - A button held through reset release is debounced afresh and produces a btn_press after DEBOUNCE_CYCLES+2 cycles.
- No combinational path from btn_raw to any output.

Decomposition:
- No shared package needed. Parameters are passed per instance and counter widths are derived locally with $clog2.
- One sub-module, btn_debounce_ch: single-channel synchroniser + debounce + long-press logic with 1-bit ports, same parameters.
- btn_debounce instantiates N_BTN copies of btn_debounce_ch in a generate loop.

Test Plan:
(all scenarios at DEBOUNCE_CYCLES=4, LONG_CYCLES=16, N_BTN=3, ACTIVE_LOW=0, 10 ns clock)
1. Reset: rst_n=0 with btn_raw=3'b111 -> all outputs 0 during reset. After release, btn_level=3'b111 with btn_press=3'b111 for one cycle, 6 edges later.
2. Clean press: btn_raw[0] 0->1 and held -> btn_level[0] rises on edge 6 with a single btn_press[0] pulse. Channels 1-2 stay 0.
3. Bounce: btn_raw[1] toggles 1,0,1,0 every 2 cycles, then holds 1 -> no strobes during the toggling. btn_level[1] rises 6 edges after the final 0->1 sample.
4. Long press: hold btn_raw[2]=1 for 40 cycles -> btn_press[2] at cycle P and a single btn_long[2] at cycle P+16, with no repeat. On release, btn_release[2] fires and there is no further btn_long.
5. Short press: hold btn_raw[0]=1 for 12 cycles, then 0 -> press and release strobes, btn_long[0] never asserts.
6. Reset mid-debounce: btn_raw[1] rises, rst_n pulsed low 2 cycles later -> outputs cleared immediately. Press accepted 6 edges after reset release, with exactly one btn_press[1].
